// File: rtl/switch_bank_pkg.sv
// Shared definitions for the switch bank: lane mode encoding, the per-lane
// control token that travels with each data word, and parameter defaults
// with their legal ranges.
package switch_bank_pkg;

  // Parameter defaults and legal ranges
  localparam int SW_WIDTH_DEF    = 8;
  localparam int SW_WIDTH_MIN    = 1;
  localparam int SW_WIDTH_MAX    = 32;
  localparam int SW_CHANNELS_DEF = 4;
  localparam int SW_CHANNELS_MIN = 1;
  localparam int SW_CHANNELS_MAX = 16;
  localparam int SW_LATENCY_DEF  = 2;
  localparam int SW_LATENCY_MIN  = 1;
  localparam int SW_LATENCY_MAX  = 4;
  localparam int SW_CNT_W_DEF    = 8;

  // What a disabled lane does to its output
  typedef enum logic {
    SW_MODE_ZERO = 1'b0,
    SW_MODE_HOLD = 1'b1
  } sw_mode_e;

  // Control half of a lane token; the data word rides alongside it
  typedef struct packed {
    logic     en;
    sw_mode_e mode;
  } sw_token_t;

  localparam sw_token_t SW_TOKEN_RST = '{en: 1'b0, mode: SW_MODE_ZERO};

endpackage

// File: rtl/switch_lane.sv
// One switch lane: LATENCY-1 token capture stages followed by the output
// register. With SWITCH_BANK_PASSCNT_EN defined, a saturating counter
// tallies enabled tokens that reach the output.
module switch_lane
  import switch_bank_pkg::*;
#(
  parameter int WIDTH   = SW_WIDTH_DEF,
  parameter int LATENCY = SW_LATENCY_DEF
`ifdef SWITCH_BANK_PASSCNT_EN
  , parameter int CNT_W = SW_CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
  input  logic             stall,
`ifdef SWITCH_BANK_PASSCNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] pass_cnt,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  // Token and data presented to the output register
  sw_token_t        tok_o;
  logic [WIDTH-1:0] data_o;

  if (LATENCY == 1) begin : g_direct
    // Output register samples the input token directly
    assign tok_o  = '{en: en, mode: sw_mode_e'(mode)};
    assign data_o = data_in;
  end else begin : g_stages
    sw_token_t        tok_p  [LATENCY-1];
    logic [WIDTH-1:0] data_p [LATENCY-1];

    // Capture stages p0..pN: shift tokens forward unless stalled
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LATENCY-1; i++) begin
          tok_p[i]  <= SW_TOKEN_RST;
          data_p[i] <= '0;
        end
      end else if (!stall) begin
        tok_p[0]  <= '{en: en, mode: sw_mode_e'(mode)};
        data_p[0] <= data_in;
        for (int i = 1; i < LATENCY-1; i++) begin
          tok_p[i]  <= tok_p[i-1];
          data_p[i] <= data_p[i-1];
        end
      end
    end

    assign tok_o  = tok_p[LATENCY-2];
    assign data_o = data_p[LATENCY-2];
  end

  // Output stage: pass, zero, or hold depending on the arriving token
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (!stall) begin
      if (tok_o.en) begin
        data_out  <= data_o;
        valid_out <= 1'b1;
      end else if (tok_o.mode == SW_MODE_ZERO) begin
        data_out  <= '0;
        valid_out <= 1'b0;
      end
    end
  end

`ifdef SWITCH_BANK_PASSCNT_EN
  // Increment that sticks at the all-ones value
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Pass counter: clear wins over increment and is not blocked by stall
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      pass_cnt <= '0;
    end else if (!stall && tok_o.en) begin
      pass_cnt <= sat_inc(pass_cnt);
    end
  end
`endif

endmodule

// File: rtl/switch_bank.sv
// Bank of CHANNELS independent switch lanes sharing mode and stall.
// Optional feature macro: SWITCH_BANK_PASSCNT_EN adds cnt_clr/pass_cnt
// with one saturating pass counter per lane.
module switch_bank
  import switch_bank_pkg::*;
#(
  parameter int WIDTH    = SW_WIDTH_DEF,
  parameter int CHANNELS = SW_CHANNELS_DEF,
  parameter int LATENCY  = SW_LATENCY_DEF,
  parameter int CNT_W    = SW_CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic                      stall,
`ifdef SWITCH_BANK_PASSCNT_EN
  input  logic                      cnt_clr,
  output logic [CHANNELS*CNT_W-1:0] pass_cnt,
`endif
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       valid_out
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    switch_lane #(
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY)
`ifdef SWITCH_BANK_PASSCNT_EN
      , .CNT_W (CNT_W)
`endif
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en        (en[i]),
      .data_in   (data_in[i*WIDTH +: WIDTH]),
      .mode      (mode),
      .stall     (stall),
`ifdef SWITCH_BANK_PASSCNT_EN
      .cnt_clr   (cnt_clr),
      .pass_cnt  (pass_cnt[i*CNT_W +: CNT_W]),
`endif
      .data_out  (data_out[i*WIDTH +: WIDTH]),
      .valid_out (valid_out[i])
    );
  end

endmodule
